// File: rtl/dbg_axi_initiator.sv
// rtl/dbg_axi_initiator.sv - single-outstanding AXI4 initiator for the debug fabric
module dbg_axi_initiator #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [3:0]  req_id,
    input  logic [31:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_write,
    output logic [3:0]  rsp_id,
    output logic [1:0]  rsp_resp,
    output logic [63:0] rsp_rdata,
    output logic        rsp_idmis,
    output logic [3:0]  M_AWID,
    output logic [31:0] M_AWADDR,
    output logic        M_AWVALID,
    input  logic        M_AWREADY,
    output logic [63:0] M_WDATA,
    output logic [7:0]  M_WSTRB,
    output logic        M_WVALID,
    input  logic        M_WREADY,
    input  logic [3:0]  M_BID,
    input  logic [1:0]  M_BRESP,
    input  logic        M_BVALID,
    output logic        M_BREADY,
    output logic [3:0]  M_ARID,
    output logic [31:0] M_ARADDR,
    output logic        M_ARVALID,
    input  logic        M_ARREADY,
    input  logic [3:0]  M_RID,
    input  logic [63:0] M_RDATA,
    input  logic [1:0]  M_RRESP,
    input  logic        M_RVALID,
    output logic        M_RREADY
);

    typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, RSP} state_t;

    state_t      state_q, state_d;
    logic        write_q, write_d;
    logic [3:0]  id_q, id_d;
    logic [31:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  wstrb_q, wstrb_d;
    logic        awvalid_q, awvalid_d;
    logic        wvalid_q, wvalid_d;
    logic        arvalid_q, arvalid_d;
    logic [3:0]  rid_q, rid_d;
    logic [1:0]  resp_q, resp_d;
    logic [63:0] rdata_q, rdata_d;
    logic        idmis_q, idmis_d;
    logic        timeout;

`ifdef DBG_AXI_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
    logic [15:0] cnt_q, cnt_d;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_d   = (state_q == WRESP || state_q == RDATA) ? cnt_q + 16'd1 : '0;
    assign timeout = (cnt_q == TO_LAST);
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= IDLE;
            write_q   <= 1'b0;
            id_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rid_q     <= '0;
            resp_q    <= '0;
            rdata_q   <= '0;
            idmis_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            write_q   <= write_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            rid_q     <= rid_d;
            resp_q    <= resp_d;
            rdata_q   <= rdata_d;
            idmis_q   <= idmis_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        id_d      = id_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        arvalid_d = arvalid_q;
        rid_d     = rid_q;
        resp_d    = resp_q;
        rdata_d   = rdata_q;
        idmis_d   = idmis_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d   = req_write;
                    id_d      = req_id;
                    addr_d    = req_addr;
                    wdata_d   = req_wdata;
                    wstrb_d   = req_wstrb;
                    awvalid_d = req_write;
                    wvalid_d  = req_write;
                    arvalid_d = !req_write;
                    state_d   = req_write ? WADDR : RADDR;
                end
            end
            WADDR: begin
                if (M_AWREADY) awvalid_d = 1'b0;
                if (M_WREADY)  wvalid_d  = 1'b0;
                if ((!awvalid_q || M_AWREADY) && (!wvalid_q || M_WREADY)) state_d = WRESP;
            end
            WRESP: begin
                if (M_BVALID) begin
                    rid_d   = M_BID;
                    resp_d  = M_BRESP;
                    rdata_d = '0;
                    idmis_d = (M_BID != id_q);
                    state_d = RSP;
                end else if (timeout) begin
                    rid_d   = id_q;
                    resp_d  = 2'b11;
                    rdata_d = '0;
                    idmis_d = 1'b0;
                    state_d = RSP;
                end
            end
            RADDR: begin
                if (M_ARREADY) begin
                    arvalid_d = 1'b0;
                    state_d   = RDATA;
                end
            end
            RDATA: begin
                if (M_RVALID) begin
                    rid_d   = M_RID;
                    resp_d  = M_RRESP;
                    rdata_d = M_RDATA;
                    idmis_d = (M_RID != id_q);
                    state_d = RSP;
                end else if (timeout) begin
                    rid_d   = id_q;
                    resp_d  = 2'b11;
                    rdata_d = '0;
                    idmis_d = 1'b0;
                    state_d = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RSP);
    assign rsp_write = write_q;
    assign rsp_id    = rid_q;
    assign rsp_resp  = resp_q;
    assign rsp_rdata = rdata_q;
    assign rsp_idmis = idmis_q;

    assign M_AWID    = id_q;
    assign M_AWADDR  = addr_q;
    assign M_AWVALID = awvalid_q;
    assign M_WDATA   = wdata_q;
    assign M_WSTRB   = wstrb_q;
    assign M_WVALID  = wvalid_q;
    assign M_ARID    = id_q;
    assign M_ARADDR  = addr_q;
    assign M_ARVALID = arvalid_q;

`ifdef DBG_AXI_TIMEOUT_EN
    assign M_BREADY = (state_q == WRESP) || (state_q == IDLE);
    assign M_RREADY = (state_q == RDATA) || (state_q == IDLE);
`else
    assign M_BREADY = (state_q == WRESP);
    assign M_RREADY = (state_q == RDATA);
`endif

endmodule

// File: tb/tb_dbg_axi_initiator.sv
// tb/tb_dbg_axi_initiator.sv - directed self-checking bench for dbg_axi_initiator
module tb_dbg_axi_initiator;

    logic        CLK, RSTn;
    logic        req_valid, req_ready, req_write;
    logic [3:0]  req_id;
    logic [31:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0]  req_wstrb;
    logic        rsp_valid, rsp_ready, rsp_write, rsp_idmis;
    logic [3:0]  rsp_id;
    logic [1:0]  rsp_resp;
    logic [63:0] rsp_rdata;
    logic [3:0]  M_AWID, M_BID, M_ARID, M_RID;
    logic [31:0] M_AWADDR, M_ARADDR;
    logic        M_AWVALID, M_AWREADY, M_WVALID, M_WREADY, M_BVALID, M_BREADY;
    logic        M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;
    logic [63:0] M_WDATA, M_RDATA;
    logic [7:0]  M_WSTRB;
    logic [1:0]  M_BRESP, M_RRESP;

    int checks = 0;
    int passed = 0;
    int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;

`ifdef DBG_AXI_TIMEOUT_EN
    localparam logic [1:0] IDLE_RDY = 2'b11;
`else
    localparam logic [1:0] IDLE_RDY = 2'b00;
`endif

    dbg_axi_initiator #(.TIMEOUT(16)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_id(req_id), .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_id(rsp_id), .rsp_resp(rsp_resp), .rsp_rdata(rsp_rdata), .rsp_idmis(rsp_idmis),
        .M_AWID(M_AWID), .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
        .M_WDATA(M_WDATA), .M_WSTRB(M_WSTRB), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
        .M_BID(M_BID), .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
        .M_ARID(M_ARID), .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
        .M_RID(M_RID), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID),
        .M_RREADY(M_RREADY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (M_AWVALID && M_AWREADY) aw_hs <= aw_hs + 1;
        if (M_WVALID && M_WREADY)   w_hs  <= w_hs + 1;
        if (M_BVALID && M_BREADY)   b_hs  <= b_hs + 1;
        if (M_ARVALID && M_ARREADY) ar_hs <= ar_hs + 1;
        if (M_RVALID && M_RREADY)   r_hs  <= r_hs + 1;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic responder_clear();
        M_AWREADY = 0; M_WREADY = 0; M_BVALID = 0; M_BID = 0; M_BRESP = 0;
        M_ARREADY = 0; M_RVALID = 0; M_RID = 0; M_RDATA = 0; M_RRESP = 0;
        rsp_ready = 0;
    endtask

    task automatic issue(input logic wr, input logic [3:0] id, input logic [31:0] addr,
                         input logic [63:0] wdata, input logic [7:0] wstrb);
        req_valid = 1; req_write = wr; req_id = id; req_addr = addr;
        req_wdata = wdata; req_wstrb = wstrb;
    endtask

    task automatic test_reset();
        checks++;
        if (req_ready !== 1'b1) $display("FAIL reset_req_ready got %b exp 1", req_ready);
        else passed++;
        checks++;
        if ({M_AWVALID, M_WVALID, M_ARVALID, rsp_valid} !== 4'b0000)
            $display("FAIL reset_valids got %b exp 0000", {M_AWVALID, M_WVALID, M_ARVALID, rsp_valid});
        else passed++;
        checks++;
        if ({M_BREADY, M_RREADY} !== IDLE_RDY)
            $display("FAIL reset_readies got %b exp %b", {M_BREADY, M_RREADY}, IDLE_RDY);
        else passed++;
        checks++;
        if ({M_AWADDR, M_WDATA, rsp_rdata, rsp_id, rsp_resp} !== '0)
            $display("FAIL reset_payload got %h exp 0", {M_AWADDR, M_WDATA, rsp_rdata, rsp_id, rsp_resp});
        else passed++;
        RSTn = 1;
        tick();
    endtask

    task automatic test_write_min();
        int b0 = b_hs;
        issue(1, 4'd3, 32'h2000_0000, 64'h41, 8'hFF);
        M_AWREADY = 1; M_WREADY = 1;
        checks++;
        if (req_ready !== 1'b1) $display("FAIL wmin_req_ready got %b exp 1", req_ready);
        else passed++;
        tick();
        req_valid = 0;
        checks++;
        if ({M_AWVALID, M_WVALID, M_BREADY} !== 3'b110)
            $display("FAIL wmin_c1_valids got %b exp 110", {M_AWVALID, M_WVALID, M_BREADY});
        else passed++;
        checks++;
        if ({M_AWID, M_AWADDR, M_WDATA, M_WSTRB} !== {4'd3, 32'h2000_0000, 64'h41, 8'hFF})
            $display("FAIL wmin_payload got %h exp %h", {M_AWID, M_AWADDR, M_WDATA, M_WSTRB},
                     {4'd3, 32'h2000_0000, 64'h41, 8'hFF});
        else passed++;
        tick();
        M_AWREADY = 0; M_WREADY = 0; M_BVALID = 1; M_BID = 3; M_BRESP = 0;
        checks++;
        if ({M_AWVALID, M_WVALID, M_BREADY, rsp_valid} !== 4'b0010)
            $display("FAIL wmin_c2 got %b exp 0010", {M_AWVALID, M_WVALID, M_BREADY, rsp_valid});
        else passed++;
        tick();
        M_BVALID = 0;
        checks++;
        if ({rsp_valid, rsp_write, rsp_id, rsp_resp, rsp_rdata, rsp_idmis} !==
            {1'b1, 1'b1, 4'd3, 2'd0, 64'd0, 1'b0})
            $display("FAIL wmin_rsp got %h exp %h", {rsp_valid, rsp_write, rsp_id, rsp_resp, rsp_rdata, rsp_idmis},
                     {1'b1, 1'b1, 4'd3, 2'd0, 64'd0, 1'b0});
        else passed++;
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        checks++;
        if ({rsp_valid, req_ready, b_hs - b0} !== {1'b0, 1'b1, 32'd1})
            $display("FAIL wmin_done got rsp_valid=%b req_ready=%b b=%0d exp 0 1 1", rsp_valid, req_ready, b_hs - b0);
        else passed++;
    endtask

    task automatic test_write_split();
        int aw0 = aw_hs, w0 = w_hs, b0 = b_hs;
        issue(1, 4'd1, 32'h2000_0010, 64'h5, 8'h0F);
        tick();
        req_valid = 0; M_AWREADY = 1;
        checks++;
        if ({M_AWVALID, M_WVALID} !== 2'b11) $display("FAIL split_c1 got %b exp 11", {M_AWVALID, M_WVALID});
        else passed++;
        tick();
        M_AWREADY = 0;
        checks++;
        if ({M_AWVALID, M_WVALID, M_BREADY} !== 3'b010)
            $display("FAIL split_c2 got %b exp 010", {M_AWVALID, M_WVALID, M_BREADY});
        else passed++;
        repeat (3) tick();
        checks++;
        if ({M_AWVALID, M_WVALID, M_BREADY} !== 3'b010)
            $display("FAIL split_c5 got %b exp 010", {M_AWVALID, M_WVALID, M_BREADY});
        else passed++;
        M_WREADY = 1;
        tick();
        M_WREADY = 0; M_BVALID = 1; M_BID = 1; M_BRESP = 2'b10;
        checks++;
        if ({M_AWVALID, M_WVALID, M_BREADY} !== 3'b001)
            $display("FAIL split_c6 got %b exp 001", {M_AWVALID, M_WVALID, M_BREADY});
        else passed++;
        tick();
        checks++;
        if ({rsp_valid, rsp_write, rsp_id, rsp_resp, rsp_idmis} !== {1'b1, 1'b1, 4'd1, 2'b10, 1'b0})
            $display("FAIL split_rsp got %h exp %h", {rsp_valid, rsp_write, rsp_id, rsp_resp, rsp_idmis},
                     {1'b1, 1'b1, 4'd1, 2'b10, 1'b0});
        else passed++;
        tick();
        checks++;
        if ({aw_hs - aw0, w_hs - w0, b_hs - b0} !== {32'd1, 32'd1, 32'd1})
            $display("FAIL split_handshakes got aw=%0d w=%0d b=%0d exp 1 1 1", aw_hs - aw0, w_hs - w0, b_hs - b0);
        else passed++;
        M_BVALID = 0; rsp_ready = 1;
        tick();
        rsp_ready = 0;
    endtask

    task automatic test_read();
        issue(0, 4'd5, 32'h2000_0008, 64'h0, 8'h0);
        tick();
        req_valid = 0;
        checks++;
        if ({M_ARVALID, M_ARID, M_ARADDR} !== {1'b1, 4'd5, 32'h2000_0008})
            $display("FAIL read_ar got %h exp %h", {M_ARVALID, M_ARID, M_ARADDR}, {1'b1, 4'd5, 32'h2000_0008});
        else passed++;
        tick();
        checks++;
        if ({M_ARVALID, M_RREADY} !== 2'b10) $display("FAIL read_c2 got %b exp 10", {M_ARVALID, M_RREADY});
        else passed++;
        tick();
        M_ARREADY = 1;
        checks++;
        if (M_ARVALID !== 1'b1) $display("FAIL read_c3_arvalid got %b exp 1", M_ARVALID);
        else passed++;
        tick();
        M_ARREADY = 0; M_RVALID = 1; M_RID = 5; M_RDATA = 64'hDEAD_BEEF_0000_0001; M_RRESP = 0;
        checks++;
        if ({M_ARVALID, M_RREADY} !== 2'b01) $display("FAIL read_c4 got %b exp 01", {M_ARVALID, M_RREADY});
        else passed++;
        tick();
        M_RVALID = 0;
        checks++;
        if ({rsp_valid, rsp_write, rsp_id, rsp_resp, rsp_rdata, rsp_idmis} !==
            {1'b1, 1'b0, 4'd5, 2'd0, 64'hDEAD_BEEF_0000_0001, 1'b0})
            $display("FAIL read_rsp got %h exp %h", {rsp_valid, rsp_write, rsp_id, rsp_resp, rsp_rdata, rsp_idmis},
                     {1'b1, 1'b0, 4'd5, 2'd0, 64'hDEAD_BEEF_0000_0001, 1'b0});
        else passed++;
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
    endtask

    task automatic test_idmis();
        issue(1, 4'd2, 32'h2000_0000, 64'h42, 8'hFF);
        M_AWREADY = 1; M_WREADY = 1;
        tick();
        req_valid = 0;
        tick();
        M_AWREADY = 0; M_WREADY = 0; M_BVALID = 1; M_BID = 7; M_BRESP = 0;
        tick();
        M_BVALID = 0;
        checks++;
        if ({rsp_valid, rsp_id, rsp_idmis} !== {1'b1, 4'd7, 1'b1})
            $display("FAIL idmis_rsp got %h exp %h", {rsp_valid, rsp_id, rsp_idmis}, {1'b1, 4'd7, 1'b1});
        else passed++;
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
    endtask

    task automatic test_backpressure();
        int   hs0;
        logic stable = 1'b1;
        issue(0, 4'd4, 32'h2000_0010, 64'h0, 8'h0);
        M_ARREADY = 1;
        tick();
        req_valid = 0;
        tick();
        M_ARREADY = 0; M_RVALID = 1; M_RID = 4; M_RDATA = 64'h1234; M_RRESP = 2'b01;
        tick();
        M_RVALID = 0;
        issue(1, 4'd9, 32'h2000_0020, 64'h77, 8'hFF);
        M_BVALID = 1; M_BID = 9; M_AWREADY = 1; M_WREADY = 1; M_ARREADY = 1;
        hs0 = aw_hs + w_hs + b_hs + ar_hs + r_hs;
        for (int i = 0; i < 10; i++) begin
            if ({rsp_valid, rsp_write, rsp_id, rsp_resp, rsp_rdata, req_ready, M_AWVALID, M_WVALID, M_ARVALID} !==
                {1'b1, 1'b0, 4'd4, 2'b01, 64'h1234, 1'b0, 1'b0, 1'b0, 1'b0})
                stable = 1'b0;
            tick();
        end
        checks++;
        if (stable !== 1'b1) $display("FAIL bp_stable got %b exp 1", stable);
        else passed++;
        checks++;
        if (aw_hs + w_hs + b_hs + ar_hs + r_hs - hs0 !== 0)
            $display("FAIL bp_no_axi got %0d exp 0", aw_hs + w_hs + b_hs + ar_hs + r_hs - hs0);
        else passed++;
        M_BVALID = 0; M_ARREADY = 0; rsp_ready = 1;
        tick();
        rsp_ready = 0;
        checks++;
        if ({req_ready, rsp_valid} !== 2'b10) $display("FAIL bp_release got %b exp 10", {req_ready, rsp_valid});
        else passed++;
        tick();
        req_valid = 0;
        checks++;
        if ({M_AWVALID, M_WVALID, M_AWID, M_AWADDR} !== {1'b1, 1'b1, 4'd9, 32'h2000_0020})
            $display("FAIL bp_next_accept got %h exp %h", {M_AWVALID, M_WVALID, M_AWID, M_AWADDR},
                     {1'b1, 1'b1, 4'd9, 32'h2000_0020});
        else passed++;
        tick();
        M_AWREADY = 0; M_WREADY = 0; M_BVALID = 1; M_BID = 9; M_BRESP = 0;
        tick();
        M_BVALID = 0;
        checks++;
        if ({rsp_valid, rsp_write, rsp_id, rsp_resp} !== {1'b1, 1'b1, 4'd9, 2'd0})
            $display("FAIL bp_next_rsp got %h exp %h", {rsp_valid, rsp_write, rsp_id, rsp_resp}, {1'b1, 1'b1, 4'd9, 2'd0});
        else passed++;
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
    endtask

    task automatic test_reset_mid();
        issue(1, 4'd1, 32'h2000_0000, 64'h1, 8'h01);
        tick();
        req_valid = 0;
        checks++;
        if (M_AWVALID !== 1'b1) $display("FAIL rmid_pre got %b exp 1", M_AWVALID);
        else passed++;
        #2;
        RSTn = 0;
        responder_clear();
        #1;
        checks++;
        if ({M_AWVALID, M_WVALID, M_ARVALID, rsp_valid, req_ready} !== 5'b00001)
            $display("FAIL rmid_async got %b exp 00001", {M_AWVALID, M_WVALID, M_ARVALID, rsp_valid, req_ready});
        else passed++;
        tick();
        RSTn = 1;
        tick();
        checks++;
        if ({req_ready, M_AWVALID, M_WVALID} !== 3'b100)
            $display("FAIL rmid_after got %b exp 100", {req_ready, M_AWVALID, M_WVALID});
        else passed++;
    endtask

`ifdef DBG_AXI_TIMEOUT_EN
    task automatic test_timeout();
        int r0;
        issue(0, 4'd6, 32'h2000_0008, 64'h0, 8'h0);
        M_ARREADY = 1;
        tick();
        req_valid = 0;
        tick();
        M_ARREADY = 0;
        checks++;
        if (M_RREADY !== 1'b1) $display("FAIL to_rready got %b exp 1", M_RREADY);
        else passed++;
        repeat (15) tick();
        checks++;
        if (rsp_valid !== 1'b0) $display("FAIL to_early got %b exp 0", rsp_valid);
        else passed++;
        tick();
        checks++;
        if ({rsp_valid, rsp_write, rsp_id, rsp_resp, rsp_rdata, rsp_idmis} !==
            {1'b1, 1'b0, 4'd6, 2'b11, 64'd0, 1'b0})
            $display("FAIL to_rsp got %h exp %h", {rsp_valid, rsp_write, rsp_id, rsp_resp, rsp_rdata, rsp_idmis},
                     {1'b1, 1'b0, 4'd6, 2'b11, 64'd0, 1'b0});
        else passed++;
        rsp_ready = 1;
        tick();
        rsp_ready = 0;
        r0 = r_hs;
        M_RVALID = 1; M_RID = 6; M_RDATA = 64'hBAD;
        tick();
        M_RVALID = 0;
        checks++;
        if ({r_hs - r0, rsp_valid, req_ready} !== {32'd1, 1'b0, 1'b1})
            $display("FAIL to_late_beat got r=%0d rsp_valid=%b req_ready=%b exp 1 0 1", r_hs - r0, rsp_valid, req_ready);
        else passed++;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        RSTn = 0;
        req_valid = 0; req_write = 0; req_id = 0; req_addr = 0; req_wdata = 0; req_wstrb = 0;
        responder_clear();
        repeat (2) @(posedge CLK);
        #1;
        test_reset();
        test_write_min();
        test_write_split();
        test_read();
        test_idmis();
        test_backpressure();
        test_reset_mid();
`ifdef DBG_AXI_TIMEOUT_EN
        test_timeout();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
